// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter in front of the shared line-wide data memory.
//   Port 0 is the D-cache controller and port 1 is the I-cache/prefetch refill
//   path. One requester is granted at a time. Its request is latched into the
//   mem_* registers and held on the memory port until mem_ack_i. The ack and
//   the line then go back to the granted requester one cycle later.
//
//   Optional feature: define MEM_ARB_ROUND_ROBIN_EN to replace the fixed
//   port-0 priority with a round-robin tie-break. Without the macro, port 0
//   always wins when both ports request.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   reqN_enable_i / reqN_write_i  request and write(1)/read(0) for port N
//   reqN_addr_i / reqN_data_i     byte address and write line for port N
//   reqN_ack_o                    one-cycle done pulse for port N
//   reqN_data_o                   read line (or echoed write line), valid with
//                                 the ack and held afterwards
//   mem_enable_o / mem_write_o    memory request / write
//   mem_addr_o / mem_data_o       memory address / write line
//   mem_ack_i                     memory done (one cycle)
//   mem_data_i                    memory read line, valid the cycle after ack
//   err_o                         sticky handshake-timeout flag
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t              state_reg;
  logic                grant_reg;
  logic                mem_enable_reg;
  logic                mem_write_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_data_reg;
  logic [7:0]          wait_cnt_reg;
  logic                err_reg;
  logic                ack0_reg;
  logic                ack1_reg;
  logic [DATA_W-1:0]   data0_hold_reg;
  logic [DATA_W-1:0]   data1_hold_reg;

  logic                any_req;
  logic                winner;
  logic [7:0]          wait_cnt_next;
  logic [DATA_W-1:0]   resp_line;

  assign any_req = req0_enable_i | req1_enable_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer holds the last-granted port; on a tie the other port wins.
  logic rr_ptr_reg;

  always_comb begin
    winner = req1_enable_i & ~req0_enable_i;
    if (req0_enable_i && req1_enable_i) begin
      winner = ~rr_ptr_reg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      rr_ptr_reg <= winner;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is idle.
  assign winner = ~req0_enable_i;
`endif

  assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;

  // The read line arrives the cycle after mem_ack_i, which is the RESP cycle.
  // It therefore bypasses the hold register during the ack pulse. Writes
  // echo the latched line.
  assign resp_line = mem_write_reg ? mem_data_reg : mem_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      wait_cnt_reg   <= 8'd0;
      err_reg        <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      data0_hold_reg <= '0;
      data1_hold_reg <= '0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg      <= winner;
            mem_write_reg  <= winner ? req1_write_i : req0_write_i;
            mem_addr_reg   <= winner ? req1_addr_i  : req0_addr_i;
            mem_data_reg   <= winner ? req1_data_i  : req0_data_i;
            mem_enable_reg <= 1'b1;
            wait_cnt_reg   <= 8'd0;
            state_reg      <= MEM;
          end
        end
        MEM: begin
          wait_cnt_reg <= wait_cnt_next;
          // A completion that arrives exactly on the limit is not a timeout.
          if (!mem_ack_i && wait_cnt_next >= TIMEOUT_L) begin
            err_reg <= 1'b1;
          end
          if (mem_ack_i) begin
            mem_enable_reg <= 1'b0;
            ack0_reg       <= ~grant_reg;
            ack1_reg       <= grant_reg;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (grant_reg) begin
            data1_hold_reg <= resp_line;
          end else begin
            data0_hold_reg <= resp_line;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req0_ack_o   = ack0_reg;
  assign req1_ack_o   = ack1_reg;
  assign req0_data_o  = ack0_reg ? resp_line : data0_hold_reg;
  assign req1_data_o  = ack1_reg ? resp_line : data1_hold_reg;
  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_data_o   = mem_data_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0_enable_i, req0_write_i, req0_ack_o;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_data_i, req0_data_o;
  logic          req1_enable_i, req1_write_i, req1_ack_o;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_data_i, req1_data_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(31)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .err_o(err_o)
  );

  // 10-cycle memory: ack in the 10th enable cycle, read line one cycle later.
  logic [DW-1:0] mem_array [16];
  int            mem_cnt;
  bit            mem_load;
  bit            mem_noack;

  assign mem_ack_i = mem_enable_o && !mem_noack && (mem_cnt == 9);

  always @(posedge clk_i) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem_array[i] <= {8{32'hA000_0000 + 32'(i)}};
      mem_data_i <= '0;
      mem_cnt    <= 0;
    end else if (!mem_enable_o) begin
      mem_cnt <= 0;
    end else if (mem_ack_i) begin
      mem_cnt <= 0;
      if (mem_write_o) mem_array[mem_addr_o[8:5]] <= mem_data_o;
      else             mem_data_i <= mem_array[mem_addr_o[8:5]];
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit en, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (port) begin
      req1_enable_i = en; req1_write_i = wr; req1_addr_i = addr; req1_data_i = data;
    end else begin
      req0_enable_i = en; req0_write_i = wr; req0_addr_i = addr; req0_data_i = data;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " mem_enable"}, DW'(mem_enable_o), '0);
    check({name, " mem_write"},  DW'(mem_write_o), '0);
    check({name, " mem_addr"},   DW'(mem_addr_o), '0);
    check({name, " mem_data"},   mem_data_o, '0);
    check({name, " ack0"},       DW'(req0_ack_o), '0);
    check({name, " ack1"},       DW'(req1_ack_o), '0);
    check({name, " data0"},      req0_data_o, '0);
    check({name, " data1"},      req1_data_o, '0);
    check({name, " err"},        DW'(err_o), '0);
  endtask

  typedef struct {
    bit            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
  } vec_t;

  // One isolated transaction. The request is driven in cycle 0 and the
  // ack is expected in cycle 11. The line must still be held in cycle 12.
  task automatic run_txn(input vec_t v, input string name);
    int            ack_cyc, en_cycles, other_ack, wr_bad, bus_bad;
    logic [DW-1:0] got;
    ack_cyc = -1; en_cycles = 0; other_ack = 0; wr_bad = 0; bus_bad = 0; got = '0;
    set_req(v.port, 1'b1, v.wr, v.addr, v.wdata);
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      tick();
      if (mem_enable_o) begin
        en_cycles++;
        if (mem_write_o !== v.wr) wr_bad++;
        if (mem_addr_o !== v.addr || (v.wr && mem_data_o !== v.wdata)) bus_bad++;
      end
      if ((v.port ? req0_ack_o : req1_ack_o) !== 1'b0) other_ack++;
      if ((v.port ? req1_ack_o : req0_ack_o) === 1'b1) begin
        ack_cyc = c;
        got = v.port ? req1_data_o : req0_data_o;
      end
    end
    set_req(v.port, 1'b0, 1'b0, '0, '0);
    check({name, " ack_cycle"}, DW'(ack_cyc), DW'(11));
    check({name, " data"}, got, v.exp_data);
    check({name, " mem_enable_cycles"}, DW'(en_cycles), DW'(10));
    check({name, " mem_write_level"}, DW'(wr_bad), '0);
    check({name, " mem_bus"}, DW'(bus_bad), '0);
    check({name, " other_ack"}, DW'(other_ack), '0);
    tick();
    check({name, " data_hold"}, v.port ? req1_data_o : req0_data_o, v.exp_data);
    check({name, " ack_pulse"}, DW'(v.port ? req1_ack_o : req0_ack_o), '0);
    $display("txn %s: port%0d %s addr %0h ack at cycle %0d", name, v.port,
             v.wr ? "write" : "read", v.addr, ack_cyc);
  endtask

  localparam logic [DW-1:0] LINE_B = {8{32'hB0B0_1111}};
  localparam logic [DW-1:0] LINE_C = {4{64'hC0FF_EE00_1234_5678}};
  localparam logic [DW-1:0] PRE_2  = {8{32'hA000_0002}};
  localparam logic [DW-1:0] PRE_F  = {8{32'hA000_000F}};

  vec_t vecs [6];
  int   ack_port [4];
  int   ack_cyc  [4];
  int   exp_port [4];

  initial begin
    rst_i = 1'b1; mem_load = 1'b1; mem_noack = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    vecs[0] = '{1'b0, 1'b0, 32'h40,  '0,     PRE_2};
    vecs[1] = '{1'b1, 1'b1, 32'h100, LINE_B, LINE_B};
    vecs[2] = '{1'b1, 1'b0, 32'h100, '0,     LINE_B};
    vecs[3] = '{1'b0, 1'b1, 32'h5C,  LINE_C, LINE_C};
    vecs[4] = '{1'b1, 1'b0, 32'h40,  '0,     LINE_C};
    vecs[5] = '{1'b0, 1'b0, 32'h1F0, '0,     PRE_F};

    tick(); tick();
    rst_i = 1'b0; mem_load = 1'b0;
    check_reset_outputs("reset_state");
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset clears the held reply lines and the arbitration pointer.
    rst_i = 1'b1; #1;
    check_reset_outputs("reset_after_traffic");
    tick(); rst_i = 1'b0; tick();

    // Both raise together. Each drops after its own ack, so port 0 is
    // served first and port 1 follows.
    begin
      int            a0, a1;
      logic [DW-1:0] d0, d1;
      a0 = -1; a1 = -1; d0 = '0; d1 = '0;
      set_req(1'b0, 1'b1, 1'b0, 32'h40,  '0);
      set_req(1'b1, 1'b1, 1'b0, 32'h1F0, '0);
      for (int c = 1; c <= 40 && (a0 < 0 || a1 < 0); c++) begin
        tick();
        if (req0_ack_o) begin a0 = c; d0 = req0_data_o; set_req(1'b0, 1'b0, 1'b0, '0, '0); end
        if (req1_ack_o) begin a1 = c; d1 = req1_data_o; set_req(1'b1, 1'b0, 1'b0, '0, '0); end
      end
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
      check("contend ack0_cycle", DW'(a0), DW'(11));
      check("contend ack1_cycle", DW'(a1), DW'(23));
      check("contend data0", d0, LINE_C);
      check("contend data1", d1, PRE_F);
      $display("txn contend: port0 ack at %0d, port1 ack at %0d", a0, a1);
      tick();
    end

    // Both held continuously for four grants.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_port = '{0, 1, 0, 1};
`else
    exp_port = '{0, 0, 0, 0};
`endif
    begin
      int n_ack, both;
      n_ack = 0; both = 0;
      set_req(1'b0, 1'b1, 1'b0, 32'h40,  '0);
      set_req(1'b1, 1'b1, 1'b0, 32'h1F0, '0);
      for (int c = 1; c <= 70 && n_ack < 4; c++) begin
        tick();
        if (req0_ack_o && req1_ack_o) both++;
        if (req0_ack_o || req1_ack_o) begin
          ack_port[n_ack] = req1_ack_o ? 1 : 0;
          ack_cyc[n_ack]  = c;
          n_ack++;
        end
      end
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
      check("held ack_count", DW'(n_ack), DW'(4));
      check("held both_acks", DW'(both), '0);
      for (int k = 0; k < n_ack; k++) begin
        check($sformatf("held grant%0d port", k), DW'(ack_port[k]), DW'(exp_port[k]));
        check($sformatf("held grant%0d cycle", k), DW'(ack_cyc[k]), DW'(11 + 12 * k));
        $display("txn held%0d: port%0d ack at cycle %0d", k, ack_port[k], ack_cyc[k]);
      end
      tick(); tick();
    end

    // Reset in the fifth cycle of a read drops it with no ack.
    begin
      int stray;
      stray = 0;
      set_req(1'b0, 1'b1, 1'b0, 32'h1F0, '0);
      for (int c = 1; c <= 5; c++) tick();
      check("midreset mem_enable_before", DW'(mem_enable_o), DW'(1));
      rst_i = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check_reset_outputs("midreset");
      tick(); tick();
      rst_i = 1'b0;
      for (int c = 0; c < 14; c++) begin
        tick();
        if (req0_ack_o || req1_ack_o || mem_enable_o) stray++;
      end
      check("midreset no_activity", DW'(stray), '0);
      $display("txn midreset: dropped read, stray events %0d", stray);
      run_txn(vecs[5], "post_reset");
    end

    // Watchdog: the memory never acks.
    mem_noack = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 32'h40, '0);
    for (int c = 1; c <= 31; c++) tick();
    check("timeout err_at_31", DW'(err_o), '0);
    check("timeout enable_at_31", DW'(mem_enable_o), DW'(1));
    tick();
    check("timeout err_at_32", DW'(err_o), DW'(1));
    for (int c = 0; c < 20; c++) tick();
    check("timeout err_sticky", DW'(err_o), DW'(1));
    check("timeout enable_held", DW'(mem_enable_o), DW'(1));
    check("timeout no_ack", DW'(req1_ack_o), '0);
    $display("txn timeout: port1 read never acked, err %0b", err_o);
    rst_i = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    check("timeout err_cleared", DW'(err_o), '0);
    check("timeout enable_cleared", DW'(mem_enable_o), '0);
    tick(); rst_i = 1'b0; mem_noack = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
